// File: rtl/mux8_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 8-input round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotated priority encoder: first set request scanning ptr, ptr+1, ... modulo 8. Purely combinational.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  // Walk from the farthest offset back to ptr so the nearest set bit is written last.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = ptr + SEL_W'(k);
      if (req[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter / select sequencer for the shared 8:1 mux; one-cycle grant latency, one bubble per release.
// Define MUX8_ARB_HOLD_LIMIT_EN to force release after MAX_HOLD accepted beats; otherwise the owner holds until its req drops.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             beat_done,
  output logic             busy
);

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic             w_owner_req;
  logic             w_beat;
  logic             w_release;

  rr_pick8 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_owner_req = req[r_sel];
  assign w_beat      = (r_state == GRANT) && w_owner_req && out_ready;

`ifdef MUX8_ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  assign w_release = !w_owner_req || (w_beat && (r_cnt == CNT_W'(MAX_HOLD - 1)));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == IDLE) begin
      w_cnt_nxt = '0;
    end else if (w_beat) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  logic [CNT_W-1:0] w_unused_hold;

  assign w_unused_hold = CNT_W'(MAX_HOLD);
  assign w_release     = !w_owner_req;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = onehot8(w_idx);
          w_sel_nxt   = w_idx;
        end
      end
      GRANT: begin
        // sel is left alone on release so the mux input does not move during the bubble.
        if (w_release) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_sel + SEL_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign busy      = (r_state == GRANT);
  assign out_valid = (r_state == GRANT) && w_owner_req;
  assign beat_done = w_beat;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed vector table, corner sequences, random traffic vs. a queue-free reference model.
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 4;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       out_valid;
  logic       beat_done;
  logic       busy;
  logic [13:0] w_dut;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index (-1 when idle), rotation start, last select, beats in this grant.
  int         m_owner = -1;
  int         m_ptr   = 0;
  logic [2:0] m_sel   = 3'd0;
  int         m_beats = 0;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .beat_done (beat_done),
    .busy      (busy)
  );

  assign w_dut = {gnt, sel, out_valid, beat_done, busy};

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       v;
    logic       d;
    logic       b;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] model_out();
    logic [7:0] g;
    logic       v;
    logic       b;
    b = (m_owner >= 0);
    g = b ? (8'h01 << m_owner) : 8'h00;
    v = b ? req[m_owner] : 1'b0;
    return {g, m_sel, v, v & out_ready, b};
  endfunction

  task automatic model_edge();
    bit v;
    bit d;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_sel   = 3'((m_ptr + k) % 8);
          m_beats = 0;
        end
      end
    end else begin
      v = req[m_owner];
      d = v & out_ready;
      if (d) m_beats++;
      if (!v || (HOLD_EN && d && m_beats == MAX_HOLD)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 3'd0;
    m_beats = 0;
  endtask

  // Called at posedge+1: drive, compare at negedge, advance model, return to posedge+1.
  task automatic step(input logic [7:0] r, input logic rd, input string name);
    req       = r;
    out_ready = rd;
    @(negedge clk);
    check(name, 32'(w_dut), 32'(model_out()));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int on_cycles;
    logic [7:0] r;

    //            req    rdy   gnt    sel   v     d     b
    tbl[0]  = '{8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'hFF, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{8'hFE, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{8'hFE, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'hFE, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{8'hFC, 1'b1, 8'h02, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{8'h90, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'h90, 1'b1, 8'h10, 3'd4, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{8'h80, 1'b1, 8'h10, 3'd4, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{8'h90, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'h90, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{8'h10, 1'b1, 8'h80, 3'd7, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{8'h11, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{8'h11, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{8'h10, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{8'h00, 1'b0, 8'h10, 3'd4, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0};

    // Reset held with every requester active: nothing may leak out.
    req       = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_out%0d", i), 32'(w_dut), 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      req       = tbl[i].req;
      out_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(w_dut),
            32'({tbl[i].gnt, tbl[i].sel, tbl[i].v, tbl[i].d, tbl[i].b}));
      model_edge();
      @(posedge clk);
      #1;
    end

    // Owner 3 drops after two beats; release lands ptr at 4.
    step(8'h08, 1'b1, "own3_idle");
    step(8'h08, 1'b1, "own3_beat1");
    step(8'h08, 1'b1, "own3_beat2");
    step(8'h00, 1'b1, "own3_drop");
    check("own3_release_gnt", 32'(gnt), 32'h0);
    check("own3_release_busy", 32'(busy), 32'h0);
    step(8'h18, 1'b1, "ptr4_idle");
    check("ptr4_pick", 32'(gnt), 32'h10);
    step(8'h00, 1'b1, "ptr4_drop");
    step(8'h00, 1'b1, "ptr4_bubble");

    // Stalled grant 2, then a 20-beat stream.
    step(8'h04, 1'b0, "own2_idle");
    for (int i = 0; i < 10; i++) step(8'h04, 1'b0, $sformatf("own2_stall%0d", i));
    check("own2_stall_held", 32'({busy, gnt}), 32'h104);
    on_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (gnt == 8'h04) on_cycles++;
      step(8'h04, 1'b1, $sformatf("own2_stream%0d", i));
    end
    check("own2_stream_owned_cycles", 32'(on_cycles), HOLD_EN ? 32'd16 : 32'd20);
    step(8'h00, 1'b1, "own2_drop");
    step(8'h00, 1'b1, "own2_bubble");

    // Park ptr at 2, grant 6, then reset on its third beat.
    step(8'h02, 1'b1, "pre_rst_idle");
    step(8'h00, 1'b1, "pre_rst_drop");
    step(8'h40, 1'b1, "own6_idle");
    step(8'h40, 1'b1, "own6_beat1");
    step(8'h40, 1'b1, "own6_beat2");
    req       = 8'h40;
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_gnt", 32'(gnt), 32'h0);
    check("rst_async_valid", 32'({out_valid, beat_done}), 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    model_reset();
    req = 8'h00;
    @(negedge clk);
    check("rst_hold", 32'(w_dut), 32'(model_out()));
    rst_n = 1'b1;
    model_edge();
    @(posedge clk);
    #1;
    step(8'h06, 1'b1, "restart_idle");
    check("restart_ptr0_pick", 32'(gnt), 32'h02);
    step(8'h00, 1'b1, "restart_drop");

    // Random traffic with sticky requests so grants last several cycles.
    r = 8'hFF;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      if (i % 150 == 0) r = 8'hFF;
      step(r, ($urandom_range(0, 3) != 0), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
